// File: rtl/crl78hcap_pkg.sv
// Shared types and defaults for the capture/backbone-mode controller.
// State codes are chosen so that adjacent phases differ in a single bit.
package crl78hcap_pkg;

  typedef enum logic [1:0] {
    BB_IDLE   = 2'b00,
    BB_ENTER  = 2'b01,
    BB_ACTIVE = 2'b11,
    BB_EXIT   = 2'b10
  } bb_state_e;

  localparam int BB_SETTLE_DEF = 4;
  localparam int BB_DRAIN_DEF  = 4;
  localparam int BB_ENTCNT_W   = 8;

  function automatic logic bb_is_busy(input bb_state_e s);
    return (s == BB_ENTER) || (s == BB_EXIT);
  endfunction

endpackage

// File: rtl/crl78hcapbbctl_if.sv
// Handshake bundle between the debug/capture controller and the BB-mode controller.
// The master is the debug side; the slave is crl78hcapbbctl.
interface crl78hcapbbctl_if;
  import crl78hcap_pkg::*;

  logic                   bb_req;
  logic                   mod_scanmode;
  logic                   capmx_bbmode;
  logic                   bb_ack;
  logic                   bb_busy;
  logic                   bb_abort;
  logic [BB_ENTCNT_W-1:0] bb_entcnt;

  modport master (
    output bb_req, mod_scanmode,
    input  capmx_bbmode, bb_ack, bb_busy, bb_abort, bb_entcnt
  );

  modport slave (
    input  bb_req, mod_scanmode,
    output capmx_bbmode, bb_ack, bb_busy, bb_abort, bb_entcnt
  );

endinterface

// File: rtl/crl78hcapbbctl.sv
// BB-mode entry/exit sequencer: 4-phase req/ack with settle/drain intervals around the
// capture clock-gate enable, and a scan-mode override that forces everything off.
module crl78hcapbbctl
  import crl78hcap_pkg::*;
#(
  parameter int SETTLE = BB_SETTLE_DEF,
  parameter int DRAIN  = BB_DRAIN_DEF,
  parameter int CNTW   = 8
) (
  input  logic             clk_fclkrt,
  input  logic             rst_sync,
  crl78hcapbbctl_if.slave  bb
);

  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] DRAIN_LAST  = CNTW'(DRAIN - 1);

  bb_state_e              state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   capmx_q, capmx_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   abort_q, abort_d;
  logic [BB_ENTCNT_W-1:0] entcnt_q, entcnt_d;

  always_ff @(posedge clk_fclkrt) begin
    if (rst_sync) begin
      state_q  <= BB_IDLE;
      cnt_q    <= '0;
      capmx_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      entcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      capmx_q  <= capmx_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
      entcnt_q <= entcnt_d;
    end
  end

  // Outputs are computed one cycle ahead so every output is a plain flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capmx_d  = capmx_q;
    ack_d    = ack_q;
    abort_d  = 1'b0;
    entcnt_d = entcnt_q;

    if (bb.mod_scanmode) begin
      state_d = BB_IDLE;
      cnt_d   = '0;
      capmx_d = 1'b0;
      ack_d   = 1'b0;
      abort_d = (state_q != BB_IDLE);
    end else begin
      case (state_q)
        BB_IDLE: begin
          if (bb.bb_req) begin
            state_d = BB_ENTER;
            cnt_d   = '0;
            capmx_d = 1'b1;
          end
        end
        BB_ENTER: begin
          // A dropped request wins over a settle interval that would complete now.
          if (!bb.bb_req) begin
            state_d = BB_EXIT;
            cnt_d   = '0;
            capmx_d = 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d  = BB_ACTIVE;
            cnt_d    = '0;
            ack_d    = 1'b1;
            entcnt_d = entcnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BB_ACTIVE: begin
          if (!bb.bb_req) begin
            state_d = BB_EXIT;
            cnt_d   = '0;
            capmx_d = 1'b0;
          end
        end
        BB_EXIT: begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = BB_IDLE;
            cnt_d   = '0;
            ack_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = BB_IDLE;
          cnt_d   = '0;
          capmx_d = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end

    busy_d = bb_is_busy(state_d);
  end

  assign bb.capmx_bbmode = capmx_q;
  assign bb.bb_ack       = ack_q;
  assign bb.bb_busy      = busy_q;
  assign bb.bb_abort     = abort_q;
  assign bb.bb_entcnt    = entcnt_q;

endmodule

// File: tb/tb_crl78hcapbbctl.sv
// Scoreboard bench for crl78hcapbbctl: expected output vectors are queued as each cycle's
// stimulus is driven and popped after the following clock edge.
module tb_crl78hcapbbctl;
  import crl78hcap_pkg::*;

  localparam int S  = 4;
  localparam int D  = 4;
  localparam int S1 = 1;
  localparam int D1 = 1;

  logic clk_fclkrt = 1'b0;
  logic rst_sync;
  always #5 clk_fclkrt = ~clk_fclkrt;

  crl78hcapbbctl_if bbm ();
  crl78hcapbbctl_if bbs ();

  crl78hcapbbctl #(.SETTLE(S), .DRAIN(D), .CNTW(8)) u_dut (
    .clk_fclkrt (clk_fclkrt),
    .rst_sync   (rst_sync),
    .bb         (bbm)
  );

  crl78hcapbbctl #(.SETTLE(S1), .DRAIN(D1), .CNTW(8)) u_short (
    .clk_fclkrt (clk_fclkrt),
    .rst_sync   (rst_sync),
    .bb         (bbs)
  );

  int         checks = 0;
  int         errors = 0;
  logic [11:0] sb_q[$];
  logic [7:0]  ent_base;

  // {capmx_bbmode, bb_ack, bb_busy, bb_abort, bb_entcnt}
  wire [11:0] obs_m = {bbm.capmx_bbmode, bbm.bb_ack, bbm.bb_busy, bbm.bb_abort, bbm.bb_entcnt};
  wire [11:0] obs_s = {bbs.capmx_bbmode, bbs.bb_ack, bbs.bb_busy, bbs.bb_abort, bbs.bb_entcnt};

  // Expected outputs k edges after bb_req is first sampled high, request dropped at edge f (f > s).
  function automatic logic [11:0] hs_exp(int k, int f, int s, int d, logic [7:0] base);
    logic cm, ak, bz;
    logic [7:0] ec;
    cm = (k >= 0) && (k < f);
    ak = (k >= s) && (k < f + d);
    bz = ((k >= 0) && (k < s)) || ((k >= f) && (k < f + d));
    ec = (k >= s) ? base + 8'd1 : base;
    return {cm, ak, bz, 1'b0, ec};
  endfunction

  task automatic test_reset();
    logic [11:0] got, e;
    rst_sync = 1'b1;
    bbm.bb_req = 1'b1; bbm.mod_scanmode = 1'b0;
    bbs.bb_req = 1'b0; bbs.mod_scanmode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(12'h000);
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, e); end
    end
    rst_sync = 1'b0;
    for (int k = 0; k <= 6 + D + 1; k++) begin
      bbm.bb_req = (k < 6);
      sb_q.push_back(hs_exp(k, 6, S, D, 8'd0));
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_release k=%0d got=%h exp=%h", k, got, e); end
    end
    ent_base = 8'd1;
  endtask

  task automatic test_handshake();
    logic [11:0] got, e;
    for (int k = -2; k <= 10 + D + 1; k++) begin
      bbm.bb_req = (k >= 0) && (k < 10);
      sb_q.push_back(hs_exp(k, 10, S, D, ent_base));
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL handshake k=%0d got=%h exp=%h", k, got, e); end
    end
    ent_base = ent_base + 8'd1;
  endtask

  task automatic test_entry_abort();
    logic [11:0] got, e;
    int alist[3] = '{1, 2, 4};
    for (int n = 0; n < 3; n++) begin
      int a;
      a = alist[n];
      for (int k = -1; k <= a + D + 1; k++) begin
        bbm.bb_req = (k >= 0) && (k < a);
        sb_q.push_back({(k >= 0) && (k < a), 1'b0, (k >= 0) && (k < a + D), 1'b0, ent_base});
        @(posedge clk_fclkrt); #1;
        got = obs_m; e = sb_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL entry_abort a=%0d k=%0d got=%h exp=%h", a, k, got, e); end
      end
    end
  endtask

  task automatic test_scan_override();
    logic [11:0] got, e;
    int plist[3] = '{2, 8, 12};
    // Scan while idle holds IDLE and never pulses bb_abort.
    for (int i = 0; i < 3; i++) begin
      bbm.bb_req = 1'b1; bbm.mod_scanmode = 1'b1;
      sb_q.push_back({4'b0000, ent_base});
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL scan_idle cyc=%0d got=%h exp=%h", i, got, e); end
    end
    for (int n = 0; n < 3; n++) begin
      int p, q;
      logic [7:0] b2;
      p  = plist[n];
      q  = p + 4;
      b2 = (S < p) ? ent_base + 8'd1 : ent_base;
      for (int k = -1; k <= q + 6 + D + 1; k++) begin
        if (k < p) begin
          bbm.mod_scanmode = 1'b0;
          bbm.bb_req = (k >= 0) && (k < 10);
          sb_q.push_back(hs_exp(k, 10, S, D, ent_base));
        end else if (k < q) begin
          bbm.mod_scanmode = 1'b1;
          bbm.bb_req = 1'b1;
          sb_q.push_back({3'b000, (k == p), b2});
        end else begin
          bbm.mod_scanmode = 1'b0;
          bbm.bb_req = (k - q < 6);
          sb_q.push_back(hs_exp(k - q, 6, S, D, b2));
        end
        @(posedge clk_fclkrt); #1;
        got = obs_m; e = sb_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL scan_override p=%0d k=%0d got=%h exp=%h", p, k, got, e); end
      end
      ent_base = b2 + 8'd1;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, e;
    int k0;
    k0 = 6 + D + 1;
    for (int k = -1; k <= k0 + 6 + D + 1; k++) begin
      bbm.bb_req = ((k >= 0) && (k < 6)) || ((k >= 8) && (k - k0 < 6));
      if (k < k0) sb_q.push_back(hs_exp(k, 6, S, D, ent_base));
      else        sb_q.push_back(hs_exp(k - k0, 6, S, D, ent_base + 8'd1));
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, e); end
    end
    ent_base = ent_base + 8'd2;
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, e;
    for (int k = -1; k <= 7; k++) begin
      rst_sync   = (k == 6);
      bbm.bb_req = (k >= 0) && (k <= 6);
      if (k < 6) sb_q.push_back(hs_exp(k, 100, S, D, ent_base));
      else       sb_q.push_back(12'h000);
      @(posedge clk_fclkrt); #1;
      got = obs_m; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid k=%0d got=%h exp=%h", k, got, e); end
    end
    rst_sync = 1'b0;
    ent_base = 8'd0;
  endtask

  task automatic test_short_timing();
    logic [11:0] got, e;
    for (int k = -1; k <= 3 + D1 + 1; k++) begin
      bbs.bb_req = (k >= 0) && (k < 3);
      sb_q.push_back(hs_exp(k, 3, S1, D1, 8'd0));
      @(posedge clk_fclkrt); #1;
      got = obs_s; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL short_handshake k=%0d got=%h exp=%h", k, got, e); end
    end
    for (int k = -1; k <= 1 + D1 + 1; k++) begin
      bbs.bb_req = (k == 0);
      sb_q.push_back({(k == 0), 1'b0, (k >= 0) && (k < 1 + D1), 1'b0, 8'd1});
      @(posedge clk_fclkrt); #1;
      got = obs_s; e = sb_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL short_abort k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_entcnt_wrap();
    logic [11:0] got, e;
    logic [7:0] start;
    start = ent_base;
    for (int h = 0; h < 256; h++) begin
      for (int k = 0; k <= S + 1 + D; k++) begin
        bbm.bb_req = (k < S + 1);
        sb_q.push_back(hs_exp(k, S + 1, S, D, ent_base));
        @(posedge clk_fclkrt); #1;
        got = obs_m; e = sb_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL wrap h=%0d k=%0d got=%h exp=%h", h, k, got, e); end
      end
      ent_base = ent_base + 8'd1;
    end
    checks++;
    if (bbm.bb_entcnt !== start) begin
      errors++; $display("FAIL wrap_final got=%0d exp=%0d", bbm.bb_entcnt, start);
    end
  endtask

  initial begin
    ent_base = 8'd0;
    test_reset();
    test_handshake();
    test_entry_abort();
    test_scan_override();
    test_back_to_back();
    test_reset_mid();
    test_short_timing();
    test_entcnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crl78hcapbbctl.md
Name: crl78hcapbbctl

Overview:
- Capture/backbone-mode controller. Sits directly upstream of the capture clock-gate stage and is the sole source of its capmx_bbmode enable.
- Sequences entry into and exit from BB mode with a 4-phase req/ack handshake toward the debug/capture controller.
- Inserts settle and drain intervals so the gated BB clocks (oscoutm, r32mout, fmain, fsub, fclkrt, r15kout) are stable before ack rises and quiet before ack falls.
- Forces BB mode off whenever scan mode is active.

Parameters:
SETTLE, 4, cycles capmx_bbmode is held high before bb_ack rises (legal range 1..255)
DRAIN, 4, cycles capmx_bbmode is held low before bb_ack falls (legal range 1..255)
CNTW, 8, width of the settle/drain counter; must hold max(SETTLE,DRAIN)-1

Ports:
clk_fclkrt  input  1  system clock (CPU clock domain)
rst_sync  input  1  synchronous active-high reset
mod_scanmode  input  1  scan mode; forces BB mode off
bb_req  input  1  BB-mode request level from debug controller, synchronous to clk_fclkrt
capmx_bbmode  output  1  registered enable to the capture clock-gate stage
bb_ack  output  1  handshake acknowledge
bb_busy  output  1  high in ENTER or EXIT
bb_abort  output  1  one-cycle pulse when scan mode aborts a non-IDLE sequence
bb_entcnt  output  8  count of completed entries; wraps 255->0

Behaviour:
- Reset and interface: one clock, clk_fclkrt. Reset is synchronous and active-high (rst_sync). While rst_sync=1 at a clock edge, the next state is: state=IDLE, cnt=0, capmx_bbmode=0, bb_ack=0, bb_busy=0, bb_abort=0, bb_entcnt=0. Reset mid-sequence drops capmx_bbmode and bb_ack on that edge. No drain interval is applied.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, ENTER, ACTIVE, EXIT.
- IDLE: bb_req=1 sampled at edge t moves to ENTER at t+1 with capmx_bbmode=1 and cnt=0.
- ENTER: cnt increments each cycle. When cnt==SETTLE-1, go to ACTIVE; bb_ack=1 from cycle t+SETTLE+1 and bb_entcnt increments on the same edge. ENTER therefore occupies exactly SETTLE cycles.
- ENTER abort: if bb_req=0 in any ENTER cycle, go to EXIT next cycle with capmx_bbmode=0 and cnt=0. bb_ack never rises and bb_entcnt does not increment.
- ACTIVE: bb_req=0 sampled at t moves to EXIT at t+1 with capmx_bbmode=0 and cnt=0. bb_ack stays 1.
- EXIT: cnt increments each cycle. When cnt==DRAIN-1, go to IDLE with bb_ack=0, so bb_ack falls at t+DRAIN+1. bb_req is ignored during EXIT.
- Re-request: if bb_req=1 in the first IDLE cycle after EXIT, ENTER starts on the next edge. This gives a minimum of one IDLE cycle between sequences, which is required for the gate stage.
- bb_busy = (state==ENTER) || (state==EXIT).
- Scan override: mod_scanmode=1 at any edge forces IDLE next cycle with capmx_bbmode=0, bb_ack=0 and cnt=0. bb_abort pulses for one cycle if the state was not IDLE.
  - While mod_scanmode=1 the block stays in IDLE regardless of bb_req.
  - Scan has priority over bb_req. rst_sync has priority over scan.
- bb_entcnt: 8-bit modulo counter. Only ENTER->ACTIVE increments it.
- capmx_bbmode toggles only on state transitions IDLE->ENTER, ENTER->EXIT, ACTIVE->EXIT, or on a scan/reset forced clear. It never glitches within a state.

Decomposition:
- Shared package crl78hcap_pkg holds:
  - state enum (IDLE=2'b00, ENTER=2'b01, ACTIVE=2'b11, EXIT=2'b10)
  - default SETTLE/DRAIN constants
  - BB_ENTCNT_W=8
- Single module. The settle/drain counter is inline; no sub-module is warranted.

Test Plan:
- Reset: assert rst_sync for 2 cycles with bb_req=1 -> all outputs 0; with bb_req still 1, capmx_bbmode=1 at first edge after reset release +1, bb_ack=1 four cycles later.
- Full handshake (SETTLE=4, DRAIN=4): bb_req rises at edge 10 -> capmx_bbmode=1 @11, bb_ack=1 @15, bb_entcnt=1. bb_req falls @20 -> capmx_bbmode=0 @21, bb_ack=0 @25, bb_busy high 11-14 and 21-24.
- Entry abort: bb_req high @10, low @12 -> capmx_bbmode 1 @11-12, 0 @13, bb_ack stays 0, IDLE @17, bb_entcnt unchanged.
- Scan override in ACTIVE: mod_scanmode=1 @30 -> capmx_bbmode=0, bb_ack=0 @31, bb_abort one-cycle pulse @31. bb_req held high, no re-entry until scan=0; entry then restarts at +1 cycle.
- Back-to-back: bb_req re-asserted during EXIT -> ignored. ENTER starts one cycle after IDLE is reached.
- Counter wrap: 256 complete handshakes -> bb_entcnt returns to 0. SETTLE=1 and DRAIN=1 variants yield bb_ack rise 2 cycles after req and fall 2 cycles after req drop.
